shift_register_unit: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with asynchronous reset, synchronous clear, parallel load, and shift/rotate modes.
- Adds a burst mode that performs AMT shifts autonomously, with BUSY/DONE status.
- Used as the general-purpose storage and serialisation element in datapath and serial-link blocks.

---
 rtl/shift_register_unit_pkg.sv | 26 ++
 rtl/shift_register_unit_next_value.sv | 35 +++
 rtl/shift_register_unit.sv | 123 ++++++++++++
 tb/tb_shift_register_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_unit_pkg.sv
// Shared types for the shift register unit.
//   shift_mode_t : operation select encoding carried on mode_i (value 7 is reserved and holds)
//   sru_state_t  : burst controller states
package shift_register_unit_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6
    } shift_mode_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SHIFTING = 1'b1
    } sru_state_t;

    // True for the modes a burst may run in (SHL..ASR).
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= 3'd2) && (mode <= 3'd6);
    endfunction

endpackage

// File: rtl/shift_register_unit_next_value.sv
// Combinational next-value function for the shift register unit.
// Used by both the single-operation path and the burst path.
//   q_i     : current register contents
//   mode_i  : operation select (shift_mode_t encoding; 7 holds)
//   d_i     : parallel load data
//   sin_l_i : serial bit entering at the MSB (SHR)
//   sin_r_i : serial bit entering at the LSB (SHL)
//   next_o  : value the register takes on the next edge
module shift_next_value
    import shift_register_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = q_i;
        case (mode_i)
            MODE_LOAD: next_o = d_i;
            MODE_SHL:  next_o = {q_i[WIDTH-2:0], sin_r_i};
            MODE_SHR:  next_o = {sin_l_i, q_i[WIDTH-1:1]};
            MODE_ROL:  next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:  next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR:  next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:   next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_register_unit.sv
// WIDTH-bit register with async reset, sync clear, parallel load, shift/rotate
// modes and an autonomous burst mode performing AMT shifts with BUSY/DONE status.
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-high reset
//   clr_i    : synchronous clear, aborts any burst
//   mode_i   : operation select
//   start_i  : request a burst of amt_i shifts in mode_i
//   amt_i    : burst shift count (values above WIDTH saturate)
//   d_i      : parallel load data
//   sin_l_i  : serial in at MSB;  sin_r_i : serial in at LSB
//   q_o      : register contents; sout_l_o/sout_r_o : MSB/LSB of q_o
//   busy_o   : burst shifts remain;  done_o : one-cycle pulse after last burst shift
module shift_register_unit
    import shift_register_unit_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              AMT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic [2:0]       mode_i,
    input  logic             start_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_l_o,
    output logic             sout_r_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    sru_state_t       state_q, state_d;
    shift_mode_t      mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] shifted;
    logic [AMT_W-1:0] amt_sat;

    // During a burst the latched mode drives the shifter; otherwise the live mode.
    assign op_mode = (state_q == ST_SHIFTING) ? mode_q : mode_i;
    assign amt_sat = (amt_i > AMT_MAX) ? AMT_MAX : amt_i;

    shift_next_value #(.WIDTH(WIDTH)) u_next (
        .q_i     (q_q),
        .mode_i  (op_mode),
        .d_i     (d_i),
        .sin_l_i (sin_l_i),
        .sin_r_i (sin_r_i),
        .next_o  (shifted)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;

        if (clr_i) begin
            // An aborted burst never reports DONE.
            q_d     = '0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_SHIFTING) begin
            q_d   = shifted;
            cnt_d = cnt_q - AMT_ONE;
            if (cnt_q == AMT_ONE) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start_i && is_shift_mode(mode_i)) begin
            if (amt_sat == '0) begin
                done_d = 1'b1;
            end else begin
                // The first shift of a burst happens on the accepting edge.
                q_d = shifted;
                if (amt_sat == AMT_ONE) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_SHIFTING;
                    cnt_d   = amt_sat - AMT_ONE;
                    mode_d  = shift_mode_t'(mode_i);
                end
            end
        end else begin
            // HOLD and the reserved encoding fall through the shifter unchanged.
            q_d = shifted;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            q_q     <= RESET_VALUE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q_o      = q_q;
    assign sout_l_o = q_q[WIDTH-1];
    assign sout_r_o = q_q[0];
    assign busy_o   = (state_q == ST_SHIFTING);
    assign done_o   = done_q;

endmodule

// File: tb/tb_shift_register_unit.sv
module tb_shift_register_unit;
    import shift_register_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [2:0]       mode;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l, sout_r, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             clr;
        logic             start;
        logic [2:0]       mode;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] d;
        logic             sin_l;
        logic             sin_r;
        logic [WIDTH-1:0] exp_q;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    shift_register_unit #(.WIDTH(WIDTH), .RESET_VALUE(8'hA5)) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .clr_i    (clr),
        .mode_i   (mode),
        .start_i  (start),
        .amt_i    (amt),
        .d_i      (d),
        .sin_l_i  (sin_l),
        .sin_r_i  (sin_r),
        .q_o      (q),
        .sout_l_o (sout_l),
        .sout_r_o (sout_r),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " q"}, q, e.q);
        check({tag, " busy"}, WIDTH'(busy), WIDTH'(e.busy));
        check({tag, " done"}, WIDTH'(done), WIDTH'(e.done));
        check({tag, " sout_l"}, WIDTH'(sout_l), WIDTH'(e.q[WIDTH-1]));
        check({tag, " sout_r"}, WIDTH'(sout_r), WIDTH'(e.q[0]));
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        clr   = v.clr;
        start = v.start;
        mode  = v.mode;
        amt   = v.amt;
        d     = v.d;
        sin_l = v.sin_l;
        sin_r = v.sin_r;
        e.q    = v.exp_q;
        e.busy = v.exp_busy;
        e.done = v.exp_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard: empty queue", tag);
        end else begin
            check_outputs(tag, sb.pop_front());
        end
    endtask

    function automatic vec_t mk(input logic c, input logic s, input logic [2:0] m,
                                input logic [AMT_W-1:0] a, input logic [WIDTH-1:0] dd,
                                input logic sl, input logic sr,
                                input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
        vec_t v;
        v.clr = c; v.start = s; v.mode = m; v.amt = a; v.d = dd;
        v.sin_l = sl; v.sin_r = sr;
        v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        rst = 1'b1; clr = 1'b0; start = 1'b0; mode = 3'd0; amt = '0;
        d = '0; sin_l = 1'b0; sin_r = 1'b0;
        r.q = 8'hA5; r.busy = 1'b0; r.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", r);
        rst = 1'b0;

        // Single ops, reserved mode, START with non-shift mode
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'hA5,0,0));
        vecs.push_back(mk(0,0,MODE_LOAD,0,8'h81,0,0, 8'h81,0,0));
        vecs.push_back(mk(0,0,MODE_SHL ,0,8'h00,0,1, 8'h03,0,0));
        vecs.push_back(mk(0,0,MODE_ROR ,0,8'h00,0,0, 8'h81,0,0));
        vecs.push_back(mk(0,0,MODE_ASR ,0,8'h00,0,0, 8'hC0,0,0));
        vecs.push_back(mk(0,0,MODE_SHR ,0,8'h00,1,0, 8'hE0,0,0));
        vecs.push_back(mk(0,0,MODE_ROL ,0,8'h00,0,0, 8'hC1,0,0));
        vecs.push_back(mk(0,0,3'd7     ,0,8'hFF,1,1, 8'hC1,0,0));
        vecs.push_back(mk(0,1,3'd7     ,4,8'hFF,1,1, 8'hC1,0,0));
        vecs.push_back(mk(0,1,MODE_LOAD,4,8'h3C,0,0, 8'h3C,0,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h3C,0,0));
        // ROL burst of 3; MODE/D/START changes while busy are ignored
        vecs.push_back(mk(0,0,MODE_LOAD,0,8'h01,0,0, 8'h01,0,0));
        vecs.push_back(mk(0,1,MODE_ROL ,3,8'h00,0,0, 8'h02,1,0));
        vecs.push_back(mk(0,1,MODE_LOAD,7,8'hFF,0,0, 8'h04,1,0));
        vecs.push_back(mk(0,0,MODE_SHR ,0,8'h00,1,1, 8'h08,0,1));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h08,0,0));
        // AMT=0 and AMT=1
        vecs.push_back(mk(0,1,MODE_SHL ,0,8'h00,0,1, 8'h08,0,1));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h08,0,0));
        vecs.push_back(mk(0,1,MODE_SHL ,1,8'h00,0,0, 8'h10,0,1));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h10,0,0));
        // AMT=15 saturates to 8 SHR shifts
        vecs.push_back(mk(0,0,MODE_LOAD,0,8'hFF,0,0, 8'hFF,0,0));
        vecs.push_back(mk(0,1,MODE_SHR ,15,8'h00,0,0, 8'h7F,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h3F,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h1F,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h0F,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h07,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h03,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h01,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h00,0,1));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h00,0,0));
        // ASR burst of 2, and live serial input during a SHL burst
        vecs.push_back(mk(0,0,MODE_LOAD,0,8'h80,0,0, 8'h80,0,0));
        vecs.push_back(mk(0,1,MODE_ASR ,2,8'h00,0,0, 8'hC0,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'hE0,0,1));
        vecs.push_back(mk(0,0,MODE_LOAD,0,8'h00,0,0, 8'h00,0,0));
        vecs.push_back(mk(0,1,MODE_SHL ,2,8'h00,0,1, 8'h01,1,0));
        vecs.push_back(mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h02,0,1));
        // CLR in idle beats START
        vecs.push_back(mk(1,1,MODE_SHL ,3,8'h00,0,1, 8'h00,0,0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Abort: CLR on the 2nd cycle of an AMT=5 SHL burst, then a new burst
        apply("abort load",  mk(0,0,MODE_LOAD,0,8'h01,0,0, 8'h01,0,0));
        apply("abort start", mk(0,1,MODE_SHL ,5,8'h00,0,0, 8'h02,1,0));
        apply("abort clr",   mk(1,0,MODE_HOLD,0,8'h00,0,0, 8'h00,0,0));
        apply("abort quiet", mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h00,0,0));
        apply("restart 1",   mk(0,1,MODE_SHL ,2,8'h00,0,1, 8'h01,1,0));
        apply("restart 2",   mk(0,0,MODE_HOLD,0,8'h00,0,1, 8'h03,0,1));
        apply("restart 3",   mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'h03,0,0));

        // Asynchronous reset in the middle of a burst, between clock edges
        apply("rst burst",   mk(0,1,MODE_ROL ,6,8'h00,0,0, 8'h06,1,0));
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async rst", r);
        rst = 1'b0;
        apply("post rst",    mk(0,0,MODE_HOLD,0,8'h00,0,0, 8'hA5,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
